imem_responder: RTL and testbench
=================================

IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 64, meaning the number of 32-bit instruction words stored (power of two).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port go, input, 1 bit: enables acceptance of new requests.
REQ-005 SHALL have port flush, input, 1 bit: branch-taken discard of queued and same-cycle fetches.
REQ-006 SHALL have port req_valid, input, 1 bit: fetch request present.
REQ-007 SHALL have port req_addr, input, 32 bits: byte address of the fetch, as driven by the program counter.
REQ-008 SHALL have port req_ready, output, 1 bit: request is accepted this cycle when high together with req_valid.
REQ-009 SHALL have port resp_valid, output, 1 bit: the queue head holds a response.
REQ-010 SHALL have port resp_ready, input, 1 bit: consumer takes the head this cycle.
REQ-011 SHALL have port resp_instr, output, 32 bits: instruction word at the head.
REQ-012 SHALL have port resp_addr, output, 32 bits: request address of the head.
REQ-013 SHALL have port resp_err, output, 1 bit: head request was misaligned or out of range.
REQ-014 SHALL have port wr_en, input, 1 bit: loader write strobe.
REQ-015 SHALL have port wr_index, input, log2(DEPTH_WORDS) bits: word index for the loader write.
REQ-016 SHALL have port wr_data, input, 32 bits: loader write data.

Function
REQ-017 SHALL hold DEPTH_WORDS x 32 storage; a loader write updates the addressed word at the clock edge where wr_en=1.
REQ-018 SHALL accept a request at an edge where req_valid=1, req_ready=1 and flush=0.
REQ-019 SHALL drive req_ready = go AND !flush AND (occupancy < 2), with no same-cycle pop bypass.
REQ-020 SHALL, on each accepted request, capture word[req_addr[2+:log2 DEPTH]], req_addr and the error flag into the response queue at that edge, so resp_valid is high in the following cycle (latency 1).
REQ-021 SHALL treat a request as an error when req_addr[1:0]!=0 or req_addr >= 4*DEPTH_WORDS; such an entry has resp_err=1 and resp_instr=0x00000013 (NOP).
REQ-022 SHALL use a 2-entry in-order queue whose occupancy state machine has states EMPTY, ONE and FULL.
REQ-023 SHALL apply these queue transitions: push only moves EMPTY->ONE or ONE->FULL; pop only moves FULL->ONE or ONE->EMPTY; a simultaneous push and pop in state ONE stays in ONE, with the new entry becoming the head.
REQ-024 SHALL pop the head at an edge where resp_valid=1 and resp_ready=1.
REQ-025 SHALL drive resp_valid=1 in states ONE and FULL; resp_instr, resp_addr and resp_err SHALL always reflect the head entry, and the head SHALL be 0 when EMPTY.
REQ-026 SHALL, when flush=1 at an edge, move to state EMPTY regardless of push, pop or go, and discard all entries.
REQ-027 SHALL return the old word on a same-edge loader write and fetch read of the same index; the new word is visible from the next accepted fetch.
REQ-028 SHALL, when go=0, accept no requests while still allowing queued responses to drain.
REQ-029 SHALL form word indices modulo DEPTH_WORDS only for in-range addresses; out-of-range addresses never alias.

Reset
REQ-030 SHALL, while reset=0, immediately force state EMPTY, resp_valid=0, resp_instr=0, resp_addr=0, resp_err=0 and req_ready=0.
REQ-031 SHALL NOT clear instruction storage on reset; contents are retained.
REQ-032 SHALL, when reset is asserted mid-operation, lose any in-flight request, with no response for it after reset release.

Verification
REQ-033 Load word1=0x00500093; go=1; request 0x4 with resp_ready=1 -> next cycle resp_valid=1, resp_instr=0x00500093, resp_addr=0x4, resp_err=0.
REQ-034 Hold resp_ready=0 and request 0x0, 0x4, 0x8 back-to-back -> first two accepted, req_ready=0 on the third; release resp_ready -> responses come out in order 0x0 then 0x4.
REQ-035 Request 0x6, then 0x100 with DEPTH_WORDS=64 -> both responses have resp_err=1 and resp_instr=0x00000013.
REQ-036 With queue FULL, assert flush for one cycle while req_valid=1 -> resp_valid=0 on the next cycle, no entry for the same-cycle request, and req_ready=0 during flush.
REQ-037 Loader writes index 2=0xDEADBEEF on the same edge a fetch of 0x8 is accepted (old value 0x00000013) -> response 0x00000013; a fetch of 0x8 on the next cycle returns 0xDEADBEEF.
REQ-038 Assert reset=0 asynchronously between edges with queue ONE -> resp_valid drops before the next edge; after release, storage still returns the previously loaded words.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: instruction memory with a 2-entry in-order response queue.
// Each accepted fetch reads its word at the accept edge. A loader port writes
// the storage, and a flush drops every queued and same-cycle fetch.
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           go,
  input  logic                           flush,
  input  logic                           req_valid,
  input  logic [31:0]                    req_addr,
  output logic                           req_ready,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [31:0]                    resp_instr,
  output logic [31:0]                    resp_addr,
  output logic                           resp_err,
  input  logic                           wr_en,
  input  logic [$clog2(DEPTH_WORDS)-1:0] wr_index,
  input  logic [31:0]                    wr_data
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [33:0] ADDR_LIMIT = 34'(DEPTH_WORDS) * 34'd4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } entry_t;

  logic [31:0] mem_q [DEPTH_WORDS];

  state_t state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;

  logic   req_err;
  logic   push;
  logic   pop;
  entry_t new_entry;

  // Loader writes; storage is not reset so a program survives a core reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_index] <= wr_data;
    end
  end

  // Classify the incoming fetch and build the entry it would push (the read sees the pre-write word).
  always_comb begin
    req_err   = (req_addr[1:0] != 2'b00) || ({2'b00, req_addr} >= ADDR_LIMIT);
    new_entry = '{instr: (req_err ? NOP_INSTR : mem_q[req_addr[2 +: AW]]),
                  addr:  req_addr,
                  err:   req_err};
  end

  // Handshakes and occupancy next-state; flush overrides every push and pop.
  always_comb begin
    req_ready  = reset && go && !flush && (state_q != FULL);
    push       = req_valid && req_ready;
    resp_valid = (state_q != EMPTY);
    pop        = resp_valid && resp_ready;
    state_d    = state_q;
    head_d     = head_q;
    tail_d     = tail_q;
    if (flush) begin
      state_d = EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            head_d  = new_entry;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_d = new_entry;
          end else if (push) begin
            state_d = FULL;
            tail_d  = new_entry;
          end else if (pop) begin
            state_d = EMPTY;
            head_d  = '0;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            head_d  = tail_q;
            tail_d  = '0;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = '0;
          tail_d  = '0;
        end
      endcase
    end
  end

  // Queue state register; an asynchronous reset empties it and zeroes both entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign resp_instr = head_q.instr;
  assign resp_addr  = head_q.addr;
  assign resp_err   = head_q.err;

endmodule

// File: tb/tb_imem_responder.sv
// Testbench for imem_responder: a scoreboard of expected responses plus directed scenarios and a random phase.
module tb_imem_responder;

  localparam int DEPTH = 64;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        go;
  logic        flush;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_instr;
  logic [31:0] resp_addr;
  logic        resp_err;
  logic        wr_en;
  logic [5:0]  wr_index;
  logic [31:0] wr_data;

  int          n_checks;
  int          n_fail;
  exp_t        sbq[$];
  logic [31:0] model_mem [DEPTH];

  imem_responder #(.DEPTH_WORDS(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .go         (go),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_instr (resp_instr),
    .resp_addr  (resp_addr),
    .resp_err   (resp_err),
    .wr_en      (wr_en),
    .wr_index   (wr_index),
    .wr_data    (wr_data)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h required %h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of request/consumer inputs, then advance to just after the next rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic rr, input logic fl);
    req_valid  = v;
    req_addr   = a;
    resp_ready = rr;
    flush      = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t predict(input logic [31:0] a);
    exp_t e;
    e.addr = a;
    e.err  = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    if (e.err) begin
      e.instr = 32'h0000_0013;
    end else begin
      e.instr = model_mem[a[7:2]];
    end
    return e;
  endfunction

  // Scoreboard monitor: on each falling edge, check the handshake and head outputs, then mirror the coming edge.
  always @(negedge clk) begin
    logic exp_ready;
    if (!reset) begin
      sbq.delete();
    end
    exp_ready = reset && go && !flush && (sbq.size() < 2);
    checkOutput("req_ready", {31'b0, req_ready}, {31'b0, exp_ready});
    checkOutput("resp_valid", {31'b0, resp_valid}, {31'b0, (sbq.size() != 0)});
    if (sbq.size() == 0) begin
      checkOutput("empty_instr", resp_instr, 32'h0);
      checkOutput("empty_addr", resp_addr, 32'h0);
      checkOutput("empty_err", {31'b0, resp_err}, 32'h0);
    end else begin
      checkOutput("head_instr", resp_instr, sbq[0].instr);
      checkOutput("head_addr", resp_addr, sbq[0].addr);
      checkOutput("head_err", {31'b0, resp_err}, {31'b0, sbq[0].err});
    end
    if (reset) begin
      if (flush) begin
        sbq.delete();
      end else begin
        if (resp_ready && sbq.size() != 0) begin
          void'(sbq.pop_front());
        end
        if (req_valid && exp_ready) begin
          sbq.push_back(predict(req_addr));
        end
      end
    end
    if (wr_en) begin
      model_mem[wr_index] = wr_data;
    end
  end

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    go         = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    req_addr   = 32'h0;
    resp_ready = 1'b0;
    wr_en      = 1'b0;
    wr_index   = 6'd0;
    wr_data    = 32'h0;
    #1 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", {31'b0, req_ready}, 32'h0);
    checkOutput("reset_valid", {31'b0, resp_valid}, 32'h0);
    reset = 1'b1;

    // Load the program image.
    for (int i = 0; i < DEPTH; i++) begin
      wr_en    = 1'b1;
      wr_index = 6'(i);
      if (i == 1) wr_data = 32'h0050_0093;
      else if (i == 2) wr_data = 32'h0000_0013;
      else wr_data = 32'hA000_0000 | (32'(i) * 32'h0001_0101);
      @(posedge clk);
      #1;
    end
    wr_en = 1'b0;
    go    = 1'b1;

    // Basic fetch with latency one.
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0);
    checkOutput("basic_valid", {31'b0, resp_valid}, 32'h1);
    checkOutput("basic_instr", resp_instr, 32'h0050_0093);
    checkOutput("basic_addr", resp_addr, 32'h4);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure: two accepted, third refused, in-order drain.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0);
    req_addr = 32'h8;
    #1 checkOutput("full_ready", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("full_head", resp_addr, 32'h0);
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Misaligned and out-of-range fetches.
    applyStimulus(1'b1, 32'h6, 1'b1, 1'b0);
    checkOutput("misalign_err", {31'b0, resp_err}, 32'h1);
    checkOutput("misalign_nop", resp_instr, 32'h0000_0013);
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0);
    checkOutput("oor_err", {31'b0, resp_err}, 32'h1);
    checkOutput("oor_addr", resp_addr, 32'h100);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Flush with a full queue and a same-cycle request.
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0);
    flush    = 1'b1;
    req_addr = 32'h8;
    #1 checkOutput("flush_ready", {31'b0, req_ready}, 32'h0);
    @(posedge clk);
    #1;
    flush     = 1'b0;
    req_valid = 1'b0;
    checkOutput("flush_valid", {31'b0, resp_valid}, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Loader write racing a fetch of the same word.
    wr_en    = 1'b1;
    wr_index = 6'd2;
    wr_data  = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0);
    wr_en = 1'b0;
    checkOutput("wr_race_old", resp_instr, 32'h0000_0013);
    applyStimulus(1'b1, 32'h8, 1'b1, 1'b0);
    checkOutput("wr_race_new", resp_instr, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset mid-operation with one entry queued and a request in flight.
    applyStimulus(1'b1, 32'h4, 1'b0, 1'b0);
    req_addr = 32'h0;
    #2 reset = 1'b0;
    #1;
    checkOutput("async_valid", {31'b0, resp_valid}, 32'h0);
    checkOutput("async_ready", {31'b0, req_ready}, 32'h0);
    checkOutput("async_instr", resp_instr, 32'h0);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0);
    checkOutput("retained", resp_instr, 32'h0050_0093);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Random traffic against the scoreboard.
    for (int c = 0; c < 400; c++) begin
      int unsigned sel;
      int unsigned idx;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      idx = $urandom_range(0, DEPTH - 1);
      if (sel < 7) a = 32'(idx) * 4;
      else if (sel == 7) a = 32'(idx) * 4 + 32'($urandom_range(1, 3));
      else if (sel == 8) a = 32'h100 + 32'(idx) * 4;
      else a = $urandom;
      go       = ($urandom_range(0, 9) < 8);
      wr_en    = ($urandom_range(0, 9) == 0);
      wr_index = 6'($urandom_range(0, DEPTH - 1));
      wr_data  = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), a, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 19) == 0));
    end
    wr_en = 1'b0;

    // Drain whatever is left, bounded.
    go = 1'b0;
    for (int c = 0; c < 10 && sbq.size() != 0; c++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    end
    checkOutput("drain_empty", 32'(sbq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
